// File: rtl/addr_scan_ctrl_if.sv
// Bus bundle for addr_scan_ctrl: sweep configuration in, sweep address and
// pulses out. The step input exists only when ADDR_SCAN_STEP_EN is defined.
interface addr_scan_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DIV_W  = 25
);
  logic [DIV_W-1:0]  tick_period;
  logic              pause;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] lo;
  logic [ADDR_W-1:0] hi;
  logic              load;
  logic [ADDR_W-1:0] load_addr;
`ifdef ADDR_SCAN_STEP_EN
  logic              step;
`endif
  logic [ADDR_W-1:0] addr_o;
  logic              tick_o;
  logic              wrap_o;

  // Controller side: drives configuration, observes the sweep.
  modport master (
`ifdef ADDR_SCAN_STEP_EN
    output step,
`endif
    output tick_period, pause, mode, lo, hi, load, load_addr,
    input  addr_o, tick_o, wrap_o
  );

  // Sweep generator side.
  modport slave (
`ifdef ADDR_SCAN_STEP_EN
    input  step,
`endif
    input  tick_period, pause, mode, lo, hi, load, load_addr,
    output addr_o, tick_o, wrap_o
  );
endinterface

// File: rtl/addr_scan_ctrl.sv
// addr_scan_ctrl: programmable sweep-address generator with an internal tick
// prescaler. Modes: up-wrap, down-wrap, ping-pong, hold over [lo, hi], plus
// pause and direct load. Optional single-step via macro ADDR_SCAN_STEP_EN
// (2-flop synchroniser + edge register; one advance per rising edge while
// paused).
module addr_scan_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DIV_W  = 25
) (
  input logic           clk,
  input logic           rst,
  addr_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PING = 2'b10,
    MODE_HOLD = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [DIV_W-1:0]  CNT_ONE  = DIV_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [DIV_W-1:0]  cnt_r;
  logic [ADDR_W-1:0] addr_r;
  dir_t              dir_r;
  logic              tick_r;
  logic              wrap_r;

  logic [DIV_W-1:0]  cnt_nxt_s;
  logic              adv_s;
  logic              step_adv_s;
  logic [ADDR_W-1:0] addr_nxt_s;
  dir_t              dir_nxt_s;
  logic              tick_nxt_s;
  logic              wrap_nxt_s;
  mode_t             mode_s;

  assign mode_s = mode_t'(bus.mode);

`ifdef ADDR_SCAN_STEP_EN
  logic step_sync1_r;
  logic step_sync2_r;
  logic step_edge_r;

  // Bring the button level into the clock domain and keep last value for edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_sync1_r <= 1'b0;
      step_sync2_r <= 1'b0;
      step_edge_r  <= 1'b0;
    end else begin
      step_sync1_r <= bus.step;
      step_sync2_r <= step_sync1_r;
      step_edge_r  <= step_sync2_r;
    end
  end

  assign step_adv_s = step_sync2_r & ~step_edge_r;
`else
  assign step_adv_s = 1'b0;
`endif

  // Prescaler: count to tick_period, then request an advance; frozen on pause.
  always_comb begin
    cnt_nxt_s = cnt_r;
    adv_s     = 1'b0;
    if (bus.pause == 1'b0) begin
      if (cnt_r >= bus.tick_period) begin
        cnt_nxt_s = '0;
        adv_s     = 1'b1;
      end else begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
    end else begin
      // A paused sweep only moves on a synchronised step edge.
      adv_s = step_adv_s;
    end
  end

  // Next address/direction/pulses if an advance happens this cycle.
  always_comb begin
    addr_nxt_s = addr_r;
    dir_nxt_s  = dir_r;
    tick_nxt_s = 1'b1;
    wrap_nxt_s = 1'b0;
    if (mode_s == MODE_HOLD) begin
      // Hold freezes the address outright, even in odd windows.
      tick_nxt_s = 1'b0;
    end else if (bus.lo >= bus.hi) begin
      addr_nxt_s = bus.lo;
    end else if ((addr_r < bus.lo) || (addr_r > bus.hi)) begin
      // Range recovery: snap to the end the sweep would start from.
      wrap_nxt_s = 1'b1;
      if (mode_s == MODE_DOWN) begin
        addr_nxt_s = bus.hi;
      end else begin
        addr_nxt_s = bus.lo;
      end
      if (mode_s == MODE_PING) begin
        dir_nxt_s = DIR_UP;
      end else begin
        dir_nxt_s = dir_r;
      end
    end else begin
      case (mode_s)
        MODE_UP: begin
          if (addr_r == bus.hi) begin
            addr_nxt_s = bus.lo;
            wrap_nxt_s = 1'b1;
          end else begin
            addr_nxt_s = addr_r + ADDR_ONE;
          end
        end
        MODE_DOWN: begin
          if (addr_r == bus.lo) begin
            addr_nxt_s = bus.hi;
            wrap_nxt_s = 1'b1;
          end else begin
            addr_nxt_s = addr_r - ADDR_ONE;
          end
        end
        MODE_PING: begin
          // Turnaround steps away from the endpoint so it is never shown twice.
          if (dir_r == DIR_UP) begin
            if (addr_r == bus.hi) begin
              dir_nxt_s  = DIR_DOWN;
              addr_nxt_s = bus.hi - ADDR_ONE;
              wrap_nxt_s = 1'b1;
            end else begin
              addr_nxt_s = addr_r + ADDR_ONE;
            end
          end else begin
            if (addr_r == bus.lo) begin
              dir_nxt_s  = DIR_UP;
              addr_nxt_s = bus.lo + ADDR_ONE;
              wrap_nxt_s = 1'b1;
            end else begin
              addr_nxt_s = addr_r - ADDR_ONE;
            end
          end
        end
        default: begin
          tick_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Sweep state: reset, then load, then advance; pulses last a single cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= '0;
      addr_r <= '0;
      dir_r  <= DIR_UP;
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
    end else if (bus.load) begin
      // Load wins over a coincident advance, which is simply dropped.
      cnt_r  <= '0;
      addr_r <= bus.load_addr;
      dir_r  <= DIR_UP;
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      if (adv_s) begin
        addr_r <= addr_nxt_s;
        dir_r  <= dir_nxt_s;
        tick_r <= tick_nxt_s;
        wrap_r <= wrap_nxt_s;
      end else begin
        tick_r <= 1'b0;
        wrap_r <= 1'b0;
      end
    end
  end

  assign bus.addr_o = addr_r;
  assign bus.tick_o = tick_r;
  assign bus.wrap_o = wrap_r;

endmodule

// File: tb/tb_addr_scan_ctrl.sv
// Directed bench for addr_scan_ctrl with hand-computed expected values.
// Step-button checks are compiled in when ADDR_SCAN_STEP_EN is defined.
module tb_addr_scan_ctrl;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  int pp_addr [7] = '{1, 2, 3, 2, 1, 0, 1};
  int pp_wrap [7] = '{0, 0, 0, 1, 0, 0, 1};

  addr_scan_ctrl_if #(.ADDR_W(5), .DIV_W(25)) bus ();

  addr_scan_ctrl #(.ADDR_W(5), .DIV_W(25)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input int a, input int t, input int w);
    chk({tag, ".addr"}, 32'(bus.addr_o), a);
    chk({tag, ".tick"}, 32'(bus.tick_o), t);
    chk({tag, ".wrap"}, 32'(bus.wrap_o), w);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.tick_period = 25'd3;
    bus.pause       = 1'b0;
    bus.mode        = 2'b00;
    bus.lo          = 5'd2;
    bus.hi          = 5'd5;
    bus.load        = 1'b0;
    bus.load_addr   = 5'd0;
`ifdef ADDR_SCAN_STEP_EN
    bus.step        = 1'b0;
`endif

    // Reset state
    #3;
    chk3("reset", 0, 0, 0);
    cyc(2);
    chk3("reset_held", 0, 0, 0);
    rst = 1'b0;

    // Up-wrap, tick_period=3: first advance is a range recovery to lo
    cyc(3);
    chk3("up_pre", 0, 0, 0);
    cyc(1);
    chk3("up_rec", 2, 1, 1);
    cyc(1);
    chk3("up_pulse_end", 2, 0, 0);
    cyc(3);
    chk3("up_3", 3, 1, 0);
    cyc(4);
    chk3("up_4", 4, 1, 0);
    cyc(4);
    chk3("up_5", 5, 1, 0);
    cyc(4);
    chk3("up_wrap", 2, 1, 1);

    // Ping-pong 0..3 with an advance every cycle
    bus.load = 1'b1; bus.load_addr = 5'd0; bus.mode = 2'b10;
    bus.lo = 5'd0; bus.hi = 5'd3; bus.tick_period = 25'd0;
    cyc(1);
    chk3("pp_load", 0, 0, 0);
    bus.load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      chk3($sformatf("pp_%0d", i), pp_addr[i], 1, pp_wrap[i]);
    end

    // Load coincident with an advance; next advance recovers from 7
    bus.load = 1'b1; bus.load_addr = 5'd7; bus.mode = 2'b00;
    bus.lo = 5'd2; bus.hi = 5'd5;
    cyc(1);
    chk3("ld_win", 7, 0, 0);
    bus.load = 1'b0;
    cyc(1);
    chk3("ld_recover", 2, 1, 1);

    // Down-wrap 4..6 with a pause in the middle of a period
    bus.tick_period = 25'd3; bus.mode = 2'b01; bus.lo = 5'd4; bus.hi = 5'd6;
    bus.load = 1'b1; bus.load_addr = 5'd4;
    cyc(1);
    chk3("dn_load", 4, 0, 0);
    bus.load = 1'b0;
    cyc(3);
    chk3("dn_pre", 4, 0, 0);
    cyc(1);
    chk3("dn_wrap", 6, 1, 1);
    cyc(2);
    bus.pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("pause.addr", 32'(bus.addr_o), 6);
      chk("pause.tick", 32'(bus.tick_o), 0);
    end
    bus.pause = 1'b0;
    cyc(1);
    chk3("resume_1", 6, 0, 0);
    cyc(1);
    chk3("resume_5", 5, 1, 0);
    cyc(4);
    chk3("resume_4", 4, 1, 0);

    // Degenerate window lo=hi=9
    bus.mode = 2'b00; bus.lo = 5'd9; bus.hi = 5'd9;
    cyc(3);
    chk3("deg_pre", 4, 0, 0);
    cyc(1);
    chk3("deg_first", 9, 1, 0);
    cyc(1);
    chk3("deg_gap", 9, 0, 0);
    cyc(3);
    chk3("deg_second", 9, 1, 0);

    // Paused sweep at 3 over 0..7
    bus.pause = 1'b1; bus.lo = 5'd0; bus.hi = 5'd7;
    bus.load = 1'b1; bus.load_addr = 5'd3;
    cyc(1);
    bus.load = 1'b0;
    cyc(5);
    chk3("hold", 3, 0, 0);

`ifdef ADDR_SCAN_STEP_EN
    bus.step = 1'b1;
    cyc(2);
    chk3("step1_wait", 3, 0, 0);
    cyc(1);
    chk3("step1", 4, 1, 0);
    bus.step = 1'b0;
    cyc(4);
    bus.step = 1'b1;
    cyc(2);
    chk3("step2_wait", 4, 0, 0);
    cyc(1);
    chk3("step2", 5, 1, 0);
    bus.step = 1'b0;
    cyc(4);
    bus.step = 1'b1;
    cyc(3);
    chk3("step3", 6, 1, 0);
    cyc(50);
    chk3("step_long", 6, 0, 0);
    bus.step = 1'b0;
    cyc(5);
    chk3("step_release", 6, 0, 0);
`endif

    // Asynchronous reset in the middle of a cycle
    #2;
    rst = 1'b1;
    #1;
    chk3("async_rst", 0, 0, 0);
    cyc(1);
    chk3("rst_held", 0, 0, 0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
